// File: rtl/awgn_taus_urng_if.sv
// ---------------------------------------------------------------------------
// awgn_taus_urng_if
//   Handshake bundle between the AWGN uniform generator and its user.
//   en        : advance request while running
//   seed_wr   : seed word strobe
//   seed_data : 32-bit seed word
//   u0        : 48-bit uniform sample for the log/sqrt magnitude path
//   u1        : 16-bit uniform sample for the sin/cos phase input
//   valid     : u0/u1 hold a fresh post-warm-up sample
// ---------------------------------------------------------------------------
interface awgn_taus_urng_if;
  logic        en;
  logic        seed_wr;
  logic [31:0] seed_data;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        valid;

  modport master (
    output en, seed_wr, seed_data,
    input  u0, u1, valid
  );

  modport slave (
    input  en, seed_wr, seed_data,
    output u0, u1, valid
  );
endinterface

// File: rtl/awgn_taus_urng.sv
// ---------------------------------------------------------------------------
// awgn_taus_urng
//   Two independent taus88 combined-Tausworthe generators (A and B).
//   u0 = {outA[31:0], outB[31:16]}, u1 = outB[15:0], one pair per advance.
//   Seeds are loaded six words at a time (A1..A3, B1..B3); after reset or a
//   complete seed load, WARMUP free-running advances are discarded.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of awgn_taus_urng_if (en, seed_wr, seed_data, u0, u1, valid)
// ---------------------------------------------------------------------------
module awgn_taus_urng #(
  parameter int unsigned WARMUP  = 16,
  parameter logic [31:0] SEED_A1 = 32'h1234_5678,
  parameter logic [31:0] SEED_A2 = 32'h89AB_CDEF,
  parameter logic [31:0] SEED_A3 = 32'h0F0F_0F0F,
  parameter logic [31:0] SEED_B1 = 32'hDEAD_BEEF,
  parameter logic [31:0] SEED_B2 = 32'hCAFE_F00D,
  parameter logic [31:0] SEED_B3 = 32'h1357_9BDF
) (
  input  logic            clk,
  input  logic            rst,
  awgn_taus_urng_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  widx;
  logic [7:0]  warm_cnt;
  logic [31:0] a1, a2, a3, b1, b2, b3;
  logic [31:0] na1, na2, na3, nb1, nb2, nb3;
  logic [31:0] out_a, out_b;
  logic        advance;
  logic        seed_load;
  logic [2:0]  slot;
  logic [31:0] seed_word;

  function automatic logic [31:0] taus_s1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] taus_s2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] taus_s3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  // A seed below a component's minimum would lock that component in a
  // degenerate cycle, so it is swapped for the default seed of that slot.
  function automatic logic [31:0] legalize(input logic [2:0] idx, input logic [31:0] w);
    logic [31:0] r;
    case (idx)
      3'd0:    r = (w < 32'd2)  ? SEED_A1 : w;
      3'd1:    r = (w < 32'd8)  ? SEED_A2 : w;
      3'd2:    r = (w < 32'd16) ? SEED_A3 : w;
      3'd3:    r = (w < 32'd2)  ? SEED_B1 : w;
      3'd4:    r = (w < 32'd8)  ? SEED_B2 : w;
      3'd5:    r = (w < 32'd16) ? SEED_B3 : w;
      default: r = w;
    endcase
    return r;
  endfunction

  // Next generator state and the combined outputs taken from the new state
  always_comb begin
    na1       = taus_s1(a1);
    na2       = taus_s2(a2);
    na3       = taus_s3(a3);
    nb1       = taus_s1(b1);
    nb2       = taus_s2(b2);
    nb3       = taus_s3(b3);
    out_a     = na1 ^ na2 ^ na3;
    out_b     = nb1 ^ nb2 ^ nb3;
    seed_word = legalize(slot, bus.seed_data);
  end

  // FSM state register plus seed index and warm-up counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_WARMUP;
      widx     <= 3'd0;
      warm_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (seed_load) begin
        // A strobe outside LOAD always consumes slot 0, so the next slot is 1.
        if (state != ST_LOAD) begin
          widx <= 3'd1;
        end else if (widx >= 3'd5) begin
          widx <= 3'd0;
        end else begin
          widx <= widx + 3'd1;
        end
      end
      if (state == ST_WARMUP && advance) begin
        warm_cnt <= warm_cnt + 8'd1;
      end else if (state != ST_WARMUP) begin
        warm_cnt <= 8'd0;
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD: begin
        if (bus.seed_wr && widx >= 3'd5) begin
          next_state = ST_WARMUP;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_WARMUP: begin
        if (bus.seed_wr) begin
          next_state = ST_LOAD;
        end else if (warm_cnt == WARM_LAST) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_WARMUP;
        end
      end
      ST_RUN: begin
        if (bus.seed_wr) begin
          next_state = ST_LOAD;
        end else begin
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_WARMUP;
    endcase
  end

  // FSM outputs: generator advance and seed slot write controls
  always_comb begin
    advance   = 1'b0;
    seed_load = 1'b0;
    slot      = widx;
    case (state)
      ST_LOAD: begin
        seed_load = bus.seed_wr;
        slot      = widx;
      end
      ST_WARMUP: begin
        if (bus.seed_wr) begin
          seed_load = 1'b1;
          slot      = 3'd0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.seed_wr) begin
          seed_load = 1'b1;
          slot      = 3'd0;
        end else begin
          advance = bus.en;
        end
      end
      default: begin
        advance   = 1'b0;
        seed_load = 1'b0;
      end
    endcase
  end

  // Generator state: step on advance, otherwise accept seed words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1 <= SEED_A1;
      a2 <= SEED_A2;
      a3 <= SEED_A3;
      b1 <= SEED_B1;
      b2 <= SEED_B2;
      b3 <= SEED_B3;
    end else if (advance) begin
      a1 <= na1;
      a2 <= na2;
      a3 <= na3;
      b1 <= nb1;
      b2 <= nb2;
      b3 <= nb3;
    end else if (seed_load) begin
      case (slot)
        3'd0:    a1 <= seed_word;
        3'd1:    a2 <= seed_word;
        3'd2:    a3 <= seed_word;
        3'd3:    b1 <= seed_word;
        3'd4:    b2 <= seed_word;
        3'd5:    b3 <= seed_word;
        default: a1 <= a1;
      endcase
    end
  end

  // Registered sample outputs; valid only for advances made in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.u0    <= 48'd0;
      bus.u1    <= 16'd0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= (state == ST_RUN) && advance;
      if (advance) begin
        bus.u0 <= {out_a, out_b[31:16]};
        bus.u1 <= out_b[15:0];
      end
    end
  end

endmodule

// File: tb/tb_awgn_taus_urng.sv
// ---------------------------------------------------------------------------
// tb_awgn_taus_urng
//   Self-checking bench for awgn_taus_urng. A behavioural model (per-component
//   taus88 table, seed list, warm-up countdown) predicts u0/u1/valid after every
//   clock edge; a compare process checks the DUT against it on each falling
//   edge. A few literal values pin the model and the reset/latency behaviour.
// ---------------------------------------------------------------------------
module tb_awgn_taus_urng;

  localparam int WARM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  awgn_taus_urng_if bus ();

  awgn_taus_urng dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  // behavioural model state
  logic [31:0] ms [6];
  int          warm_left;
  bit          loading;
  int          k_m;
  logic [47:0] eu0;
  logic [15:0] eu1;
  logic        ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed_param(input int k);
    case (k)
      0:       return 32'h1234_5678;
      1:       return 32'h89AB_CDEF;
      2:       return 32'h0F0F_0F0F;
      3:       return 32'hDEAD_BEEF;
      4:       return 32'hCAFE_F00D;
      default: return 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [31:0] legal_seed(input int k, input logic [31:0] d);
    logic [31:0] lim;
    case (k % 3)
      0:       lim = 32'd2;
      1:       lim = 32'd8;
      default: lim = 32'd16;
    endcase
    return (d < lim) ? seed_param(k) : d;
  endfunction

  // One taus88 component step, table-driven by component number.
  function automatic logic [31:0] taus_next(input int c, input logic [31:0] s);
    int q, r, sh;
    logic [31:0] m;
    case (c)
      0:       begin q = 13; r = 19; sh = 12; m = 32'hFFFF_FFFE; end
      1:       begin q = 2;  r = 25; sh = 4;  m = 32'hFFFF_FFF8; end
      default: begin q = 3;  r = 11; sh = 17; m = 32'hFFFF_FFF0; end
    endcase
    return ((s & m) << sh) ^ (((s << q) ^ s) >> r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) ms[i] = seed_param(i);
    warm_left = WARM;
    loading   = 1'b0;
    k_m       = 0;
    eu0       = 48'd0;
    eu1       = 16'd0;
    ev        = 1'b0;
  endtask

  // Predict the effect of one rising edge given the inputs applied before it.
  task automatic model_step(input logic e, input logic w, input logic [31:0] d);
    logic [31:0] oa, ob;
    ev = 1'b0;
    if (w) begin
      if (!loading) begin
        loading = 1'b1;
        k_m     = 0;
      end
      ms[k_m] = legal_seed(k_m, d);
      k_m++;
      if (k_m == 6) begin
        loading   = 1'b0;
        warm_left = WARM;
      end
    end else if (!loading && (warm_left > 0 || e)) begin
      for (int i = 0; i < 6; i++) ms[i] = taus_next(i % 3, ms[i]);
      oa  = ms[0] ^ ms[1] ^ ms[2];
      ob  = ms[3] ^ ms[4] ^ ms[5];
      eu0 = {oa, ob[31:16]};
      eu1 = ob[15:0];
      if (warm_left > 0) warm_left--;
      else ev = 1'b1;
    end
  endtask

  task automatic cycle(input logic e, input logic w, input logic [31:0] d);
    @(negedge clk);
    #2;
    bus.en        = e;
    bus.seed_wr   = w;
    bus.seed_data = d;
    model_step(e, w, d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_step(bus.en, bus.seed_wr, bus.seed_data);
  endtask

  task automatic load_seeds(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5);
    cycle(1'b1, 1'b1, w0);
    cycle(1'b1, 1'b1, w1);
    cycle(1'b0, 1'b1, w2);
    cycle(1'b1, 1'b1, w3);
    cycle(1'b0, 1'b1, w4);
    cycle(1'b1, 1'b1, w5);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) cycle(1'($urandom_range(0, 1)), 1'b0, $urandom);
  endtask

  // Compare DUT outputs with the model after every edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0", {16'd0, bus.u0}, {16'd0, eu0});
      chk("u1", {48'd0, bus.u1}, {48'd0, eu1});
      chk("valid", {63'd0, bus.valid}, {63'd0, ev});
    end
  end

  initial begin
    bus.en        = 1'b0;
    bus.seed_wr   = 1'b0;
    bus.seed_data = 32'd0;
    model_reset();

    // pin the model: seeds 2/8/16 give these first two outputs
    chk("pin_s1", {32'd0, taus_next(0, 32'd2)}, 64'h0000_2000);
    chk("pin_s2", {32'd0, taus_next(1, 32'd8)}, 64'h0000_0080);
    chk("pin_s3", {32'd0, taus_next(2, 32'd16)}, 64'h0020_0000);
    chk("pin_s3_2", {32'd0, taus_next(2, 32'h0020_0000)}, 64'h0000_2400);
    chk("pin_legal", {32'd0, legal_seed(5, 32'd15)}, 64'h1357_9BDF);

    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_u0", {16'd0, bus.u0}, 64'd0);
    chk("rst_u1", {48'd0, bus.u1}, 64'd0);
    chk("rst_valid", {63'd0, bus.valid}, 64'd0);

    // reset release with en held: 16 warm-up edges then the first RUN edge
    bus.en = 1'b1;
    release_reset();
    repeat (15) cycle(1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("valid_before_run", {63'd0, bus.valid}, 64'd0);
    cycle(1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("first_valid", {63'd0, bus.valid}, 64'd1);
    repeat (400) cycle(1'b1, 1'b0, 32'd0);

    // en toggle pattern and random en
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    run_random(600);

    // minimum legal seeds, then checked against literal first outputs
    load_seeds(32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16);
    cycle(1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("min_seed_u1_1", {48'd0, bus.u1}, 64'h2080);
    chk("min_seed_u0_1", {16'd0, bus.u0}, 64'h0020_2080_0020);
    cycle(1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("min_seed_u1_2", {48'd0, bus.u1}, 64'h2C80);
    chk("min_seed_u0_2", {16'd0, bus.u0}, 64'h0200_2C80_0200);
    chk("min_seed_valid", {63'd0, bus.valid}, 64'd0);
    repeat (60) cycle(1'b1, 1'b0, 32'd0);

    // illegal seeds fall back to parameter seeds
    load_seeds(32'd1, 32'd7, 32'd15, 32'd0, 32'd0, 32'd0);
    repeat (60) cycle(1'b1, 1'b0, 32'd0);

    // seed load interrupting RUN, with a gap mid-load
    cycle(1'b1, 1'b1, 32'hA5A5_0001);
    cycle(1'b1, 1'b1, 32'h0000_1234);
    cycle(1'b1, 1'b1, 32'h0000_5678);
    cycle(1'b1, 1'b1, 32'h7777_0003);
    repeat (6) cycle(1'b1, 1'b0, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 32'h0000_0009);
    cycle(1'b1, 1'b1, 32'h0000_0020);
    repeat (50) cycle(1'b1, 1'b0, 32'd0);

    // seed_wr during WARMUP restarts loading
    load_seeds($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (5) cycle(1'b1, 1'b0, 32'd0);
    load_seeds($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    run_random(100);

    // reset after three seed words restores the parameter-seed sequence
    cycle(1'b1, 1'b1, 32'h1111_1111);
    cycle(1'b1, 1'b1, 32'h2222_2222);
    cycle(1'b1, 1'b1, 32'h3333_3333);
    @(negedge clk); #2;
    rst           = 1'b0;
    bus.seed_wr   = 1'b0;
    bus.en        = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_u0", {16'd0, bus.u0}, 64'd0);
    chk("midrst_u1", {48'd0, bus.u1}, 64'd0);
    chk("midrst_valid", {63'd0, bus.valid}, 64'd0);
    release_reset();
    repeat (100) cycle(1'b1, 1'b0, 32'd0);

    // random seed loads with random gaps and random en
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 6; j++) begin
        cycle(1'($urandom_range(0, 1)), 1'b1, (j % 2 == 0) ? $urandom_range(0, 20) : $urandom);
        if ($urandom_range(0, 3) == 0) run_random($urandom_range(1, 4));
      end
      run_random(80);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/awgn_taus_urng.md
# awgn_taus_urng

Dual combined-Tausworthe (taus88) uniform random number generator for the AWGN datapath. It produces a 48-bit uniform `u0` for the log/sqrt magnitude path and a 16-bit uniform `u1` used directly as the phase input of the sin/cos stage. Each advance yields one (`u0`, `u1`) pair per cycle. Seeds are runtime-loadable, and a warm-up phase discards early correlated outputs.

## Interface
- `WARMUP`, 16: free-running cycles after reset or seed load before `valid` rises (1..255).
- `SEED_A1`, 32'h1234_5678: reset seed, generator A, component 1.
- `SEED_A2`, 32'h89AB_CDEF: reset seed, A, component 2.
- `SEED_A3`, 32'h0F0F_0F0F: reset seed, A, component 3.
- `SEED_B1`, 32'hDEAD_BEEF: reset seed, B, component 1.
- `SEED_B2`, 32'hCAFE_F00D: reset seed, B, component 2.
- `SEED_B3`, 32'h1357_9BDF: reset seed, B, component 3.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance request in RUN.
- `seed_wr`  in  1  seed word strobe.
- `seed_data`  in  32  seed word.
- `u0`  out  48  uniform sample, {`outA[31:0]`, `outB[31:16]`}.
- `u1`  out  16  uniform sample `outB[15:0]`, which feeds `sincos_in`.
- `valid`  out  1  `u0`/`u1` are a fresh post-warm-up sample.

## Operation
- Six 32-bit state registers: A.s1–s3 and B.s1–s3. Each generator steps with the same taus88 recurrence (all shifts are logical, all widths 32):
  - s1' = ((s1 & FFFFFFFE)<<12) ^ (((s1<<13)^s1)>>19)
  - s2' = ((s2 & FFFFFFF8)<<4) ^ (((s2<<2)^s2)>>25)
  - s3' = ((s3 & FFFFFFF0)<<17) ^ (((s3<<3)^s3)>>11)
  - out = s1'^s2'^s3' (computed from the new state).
- FSM states are LOAD, WARMUP and RUN.
  - Reset: state = WARMUP, warm-up counter = 0, seeds = parameters, `u0`=0, `u1`=0, `valid`=0.
  - LOAD: generators frozen, `valid`=0. Each `seed_wr` writes `seed_data` into slot `widx` (0..5 = A1, A2, A3, B1, B2, B3) and increments `widx`. The write with `widx`=5 sets `widx`=0, clears the warm-up counter and moves to WARMUP.
  - WARMUP: generators advance every cycle regardless of `en`, and `u0`/`u1` update each cycle, but `valid`=0. When the counter reaches `WARMUP`-1, that advance is the last one and the state moves to RUN.
  - RUN: on `en`=1, generators advance, `u0`/`u1` load the new outputs, and `valid`=1 the next cycle. On `en`=0, state and outputs hold and `valid`=0.
- `seed_wr` in WARMUP or RUN: write slot 0, set `widx`=1, go to LOAD, and the generators do not advance in that cycle. `valid` is 0 from the next cycle.
- Seed legality is enforced at write time. A word below the minimum for its slot is replaced by the corresponding `SEED_*` parameter:
  - s1 < 2
  - s2 < 8
  - s3 < 16
- `seed_data` is ignored when `seed_wr`=0. `en` is ignored outside RUN.

## Timing
- All outputs are registered, with no combinational path from input to output.
- `valid` can first be 1 at cycle `WARMUP`+2 after reset deassertion: `WARMUP` warm-up edges, then a RUN edge with `en` high.
- Sustained throughput is one sample per cycle with `en` held high, and `valid` high every cycle.
- Seed reload to first valid sample takes 6 `seed_wr` cycles (gaps allowed), `WARMUP` cycles, then 1 `en` cycle.
- Asserting reset mid-LOAD discards the partially written seeds and restores the parameter seeds.

## Test plan
- Reset release with `en`=1 held: `valid`=0 for cycles 1..17, and `u1` matches a C taus88 model seeded with the parameters, advanced 17 steps, at the first `valid`. Sequence matches the model for 10,000 samples.
- `en` toggled 1,0,0,1 in RUN: `u0`/`u1` hold during the 0 cycles, `valid` follows `en` delayed one cycle, and no sample is skipped relative to the model.
- Load seeds 2, 8, 16, 2, 8, 16 back-to-back: the sequence after 16 warm-up cycles matches the model with those seeds. Then load 1, 7, 15, 0, 0, 0: the sequence matches the model using all parameter seeds.
- `seed_wr` asserted mid-RUN, then three further words, then a 6-cycle gap, then two words: `valid`=0 throughout, the FSM enters WARMUP only after the 6th word, and the output matches the model.
- Reset pulsed after 3 seed words: `u0`=0, `u1`=0, `valid`=0 during reset, and the post-reset sequence equals the original parameter-seed sequence.
- Statistical smoke test over 2^20 samples: mean of `u1` within 0.5% of 32767.5, and each of the 16 `u1` bits is set 50%±0.5% of the time.
